// File: rtl/ascon_input_sequencer.sv
// ASCON-AEAD128 absorb sequencer: gates source words into the core and
// steers the pad unit through AD then DI blocks, incl. pad-only finals.
// Ports: clk_i/rst_ni, clear_i, start_i, ad_len_i/di_len_i (bytes),
//   src_valid_i/src_ready_o, core_valid_o/core_ready_i,
//   pad_en_o, sel_ad_o, ad_pad_idx_o, di_pad_idx_o, last_o, busy_o, done_o.
module ascon_input_sequencer #(
  parameter int LEN_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] ad_len_i,
  input  logic [LEN_W-1:0] di_len_i,
  input  logic             src_valid_i,
  output logic             src_ready_o,
  output logic             core_valid_o,
  input  logic             core_ready_i,
  output logic             pad_en_o,
  output logic             sel_ad_o,
  output logic [3:0]       ad_pad_idx_o,
  output logic [3:0]       di_pad_idx_o,
  output logic             last_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int BLOCK_WIDTH = 128;
  localparam int PAD_AW      = 4;
  localparam logic [LEN_W-1:0] BLK_BYTES =
    LEN_W'(BLOCK_WIDTH / 8);

  typedef enum logic [1:0] {
    IDLE,
    AD,
    DI
  } state_t;

  state_t             state_q;
  logic [LEN_W-1:0]   rem_q;
  logic [LEN_W-1:0]   di_len_q;
  logic               done_q;

  logic               active;
  logic               full;
  logic               last;
  logic               pad_only;
  logic [PAD_AW-1:0]  idx;
  logic               xfer;

  assign active   = (state_q != IDLE);
  assign full     = (rem_q >= BLK_BYTES);
  assign last     = active & ~full;
  // Exact multiple of the block size: padding block with no data word.
  assign pad_only = last & (rem_q == '0);
  assign idx      = last ? rem_q[PAD_AW-1:0] : '0;

  assign core_valid_o = active & (pad_only | src_valid_i);
  assign src_ready_o  = active & core_ready_i & ~pad_only;
  assign xfer         = core_valid_o & core_ready_i;

  assign pad_en_o     = last;
  assign last_o       = last;
  assign sel_ad_o     = (state_q == AD);
  assign ad_pad_idx_o = (state_q == AD) ? idx : '0;
  assign di_pad_idx_o = (state_q == DI) ? idx : '0;
  assign busy_o       = active;
  assign done_o       = done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      di_len_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clear_i) begin
        state_q <= IDLE;
        rem_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start_i) begin
              di_len_q <= di_len_i;
              if (ad_len_i != '0) begin
                state_q <= AD;
                rem_q   <= ad_len_i;
              end else begin
                state_q <= DI;
                rem_q   <= di_len_i;
              end
            end
          end
          AD: begin
            if (xfer) begin
              if (full) begin
                rem_q <= rem_q - BLK_BYTES;
              end else begin
                state_q <= DI;
                rem_q   <= di_len_q;
              end
            end
          end
          DI: begin
            if (xfer) begin
              if (full) begin
                rem_q <= rem_q - BLK_BYTES;
              end else begin
                state_q <= IDLE;
                done_q  <= 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ascon_input_sequencer.sv
// Directed bench for ascon_input_sequencer.
// Block offers are checked as packed field vectors against hand values.
module tb_ascon_input_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic        start_i;
  logic [31:0] ad_len_i;
  logic [31:0] di_len_i;
  logic        src_valid_i;
  logic        src_ready_o;
  logic        core_valid_o;
  logic        core_ready_i;
  logic        pad_en_o;
  logic        sel_ad_o;
  logic [3:0]  ad_pad_idx_o;
  logic [3:0]  di_pad_idx_o;
  logic        last_o;
  logic        busy_o;
  logic        done_o;

  int n_checks = 0;
  int n_errors = 0;
  int words;
  int xfers;
  int ad_xfers;

  always #5 clk_i = ~clk_i;

  ascon_input_sequencer #(.LEN_W(32)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .start_i      (start_i),
    .ad_len_i     (ad_len_i),
    .di_len_i     (di_len_i),
    .src_valid_i  (src_valid_i),
    .src_ready_o  (src_ready_o),
    .core_valid_o (core_valid_o),
    .core_ready_i (core_ready_i),
    .pad_en_o     (pad_en_o),
    .sel_ad_o     (sel_ad_o),
    .ad_pad_idx_o (ad_pad_idx_o),
    .di_pad_idx_o (di_pad_idx_o),
    .last_o       (last_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] offer();
    return {sel_ad_o, pad_en_o, last_o, ad_pad_idx_o,
            di_pad_idx_o, src_ready_o, core_valid_o};
  endfunction

  task automatic start_op(input logic [31:0] ad,
                          input logic [31:0] di);
    start_i  = 1'b1;
    ad_len_i = ad;
    di_len_i = di;
    @(negedge clk_i);
    start_i  = 1'b0;
    words    = 0;
    xfers    = 0;
    ad_xfers = 0;
  endtask

  // Expected fields: sel, pad_en, last, ad idx, di idx, src_ready.
  task automatic blk(input string tag,
                     input logic sel, input logic pad,
                     input logic lst,
                     input logic [3:0] ai, input logic [3:0] di,
                     input logic rdy, input int stall);
    for (int s = 0; s < stall; s++) begin
      core_ready_i = 1'b0;
      #1;
      check({tag, "_stall"}, {19'd0, offer()},
            {19'd0, sel, pad, lst, ai, di, 1'b0, 1'b1});
      @(negedge clk_i);
    end
    core_ready_i = 1'b1;
    #1;
    check(tag, {19'd0, offer()},
          {19'd0, sel, pad, lst, ai, di, rdy, 1'b1});
    if (src_ready_o && src_valid_i) words++;
    if (sel_ad_o) ad_xfers++;
    xfers++;
    @(negedge clk_i);
  endtask

  task automatic fin_done(input string tag);
    #1;
    check({tag, "_done"}, {30'd0, done_o, busy_o}, 32'd2);
    @(negedge clk_i);
    #1;
    check({tag, "_done_end"}, {31'd0, done_o}, 32'd0);
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni       = 1'b0;
    clear_i      = 1'b0;
    start_i      = 1'b0;
    ad_len_i     = '0;
    di_len_i     = '0;
    src_valid_i  = 1'b1;
    core_ready_i = 1'b1;
    #3;
    check("reset_out", {17'd0, offer(), busy_o, done_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Empty message: one pad-only DI block.
    start_op(0, 0);
    blk("t1_di", 0, 1, 1, 0, 0, 0, 0);
    fin_done("t1");
    check("t1_words", words, 0);

    // ad=16, di=5
    start_op(16, 5);
    blk("t2_ad_full", 1, 0, 0, 0, 0, 1, 0);
    blk("t2_ad_pad", 1, 1, 1, 0, 0, 0, 0);
    blk("t2_di", 0, 1, 1, 0, 5, 1, 0);
    fin_done("t2");
    check("t2_words", words, 2);
    check("t2_xfers", xfers, 3);

    // ad=20, di=32
    start_op(20, 32);
    blk("t3_ad_full", 1, 0, 0, 0, 0, 1, 0);
    blk("t3_ad_last", 1, 1, 1, 4, 0, 1, 0);
    blk("t3_di_full0", 0, 0, 0, 0, 0, 1, 0);
    blk("t3_di_full1", 0, 0, 0, 0, 0, 1, 0);
    blk("t3_di_pad", 0, 1, 1, 0, 0, 0, 0);
    fin_done("t3");
    check("t3_ad_xfers", ad_xfers, 2);
    check("t3_words", words, 4);

    // ad=3, di=17 with 4-cycle stalls on every block
    start_op(3, 17);
    blk("t4_ad", 1, 1, 1, 3, 0, 1, 4);
    blk("t4_di_full", 0, 0, 0, 0, 0, 1, 4);
    blk("t4_di_last", 0, 1, 1, 0, 1, 1, 4);
    fin_done("t4");
    check("t4_xfers", xfers, 3);

    // clear during second DI block of ad=0, di=40
    start_op(0, 40);
    blk("t5_di_full", 0, 0, 0, 0, 0, 1, 0);
    clear_i = 1'b1;
    #1;
    check("t5_clr_offer", {19'd0, offer()},
          {19'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1});
    @(negedge clk_i);
    clear_i = 1'b0;
    #1;
    check("t5_clr_idle", {29'd0, busy_o, done_o, core_valid_o}, 32'd0);
    @(negedge clk_i);
    #1;
    check("t5_clr_nodone", {31'd0, done_o}, 32'd0);
    @(negedge clk_i);
    start_op(1, 1);
    blk("t5_ad", 1, 1, 1, 1, 0, 1, 0);
    blk("t5_di", 0, 1, 1, 0, 1, 1, 0);
    fin_done("t5");
    check("t5_xfers", xfers, 2);

    // start while busy is ignored: ad=20, di=32 keeps 5 blocks
    start_op(20, 32);
    start_i  = 1'b1;
    ad_len_i = 0;
    di_len_i = 0;
    blk("t6_ad_full", 1, 0, 0, 0, 0, 1, 0);
    blk("t6_ad_last", 1, 1, 1, 4, 0, 1, 0);
    blk("t6_di_full0", 0, 0, 0, 0, 0, 1, 0);
    blk("t6_di_full1", 0, 0, 0, 0, 0, 1, 0);
    start_i = 1'b0;
    blk("t6_di_pad", 0, 1, 1, 0, 0, 0, 0);
    fin_done("t6");
    check("t6_xfers", xfers, 5);

    // async reset mid-AD
    start_op(32, 0);
    blk("t7_ad_full", 1, 0, 0, 0, 0, 1, 0);
    rst_ni = 1'b0;
    #1;
    check("t7_rst_out", {17'd0, offer(), busy_o, done_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("t7_rst_idle", {30'd0, busy_o, done_o}, 32'd0);
    @(negedge clk_i);
    #1;
    check("t7_rst_nodone", {31'd0, done_o}, 32'd0);
    @(negedge clk_i);
    start_op(0, 3);
    blk("t7_di", 0, 1, 1, 0, 3, 1, 0);
    fin_done("t7");

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
